// File: rtl/urisc_core.sv
// Single-instruction (subtract-and-branch-if-<=0) processor core.
// Fetches A, B, C from ROM, then reads Mem[A] and Mem[B] and writes Mem[B] - Mem[A], six cycles per instruction.
module urisc_core #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             rom_cs,
  output logic             rom_read,
  output logic [AW-1:0]    rom_addr,
  input  logic [AW-1:0]    rom_data,
  output logic             mem_cs,
  output logic             mem_read,
  output logic             mem_write,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             halted,
  output logic [AW-1:0]    pc,
  output logic [15:0]      instr_count
);

  typedef enum logic [2:0] {IDLE, FA, FB, FC, RA, RB, WR, HALT} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    reg_a, reg_b, reg_c;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] result;
  logic             taken;

  // Modulo-DEPTH address increment, correct even when DEPTH is not a power of two.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int unsigned n);
    logic [AW+1:0] sum;
    sum = {2'b00, base} + (AW+2)'(n);
    if (sum >= (AW+2)'(DEPTH))
      sum = sum - (AW+2)'(DEPTH);
    return sum[AW-1:0];
  endfunction

  assign result = op_b - op_a;
  assign taken  = result[WIDTH-1] || (result == '0);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr_count <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_c       <= '0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        FA: reg_a <= rom_data;
        FB: reg_b <= rom_data;
        FC: reg_c <= rom_data;
        RA: op_a  <= mem_rdata;
        RB: op_b  <= mem_rdata;
        WR: begin
          pc          <= taken ? reg_c : wrap_add(pc, 3);
          instr_count <= instr_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // The write strobe is masked by reset so an interrupted WR never commits.
  always_comb begin
    state_next = state;
    rom_cs     = 1'b0;
    rom_read   = 1'b0;
    rom_addr   = '0;
    mem_cs     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FA;
      end
      FA: begin
        busy = 1'b1; rom_cs = 1'b1; rom_read = 1'b1;
        rom_addr   = pc;
        state_next = FB;
      end
      FB: begin
        busy = 1'b1; rom_cs = 1'b1; rom_read = 1'b1;
        rom_addr   = wrap_add(pc, 1);
        state_next = FC;
      end
      FC: begin
        busy = 1'b1; rom_cs = 1'b1; rom_read = 1'b1;
        rom_addr   = wrap_add(pc, 2);
        state_next = RA;
      end
      RA: begin
        busy = 1'b1; mem_cs = 1'b1; mem_read = 1'b1;
        mem_addr   = reg_a;
        state_next = RB;
      end
      RB: begin
        busy = 1'b1; mem_cs = 1'b1; mem_read = 1'b1;
        mem_addr   = reg_b;
        state_next = WR;
      end
      WR: begin
        busy = 1'b1; mem_cs = 1'b1;
        mem_write  = !reset;
        mem_addr   = reg_b;
        mem_wdata  = result;
        state_next = (taken && reg_c == pc) ? HALT : FA;
      end
      HALT: begin
        halted = 1'b1;
        if (start) state_next = FA;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_urisc_core.sv
// Directed testbench for urisc_core: behavioural ROM and falling-edge data memory,
// hand-computed expectations for reset, branching, overflow, wrap, reset-in-WR and start-while-busy.
module tb_urisc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rom_cs, rom_read;
  logic [8:0]  rom_addr, rom_data;
  logic        mem_cs, mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, halted;
  logic [8:0]  pc;
  logic [15:0] instr_count;

  logic [8:0]  rom [0:511];
  logic [15:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  urisc_core dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_cs(rom_cs), .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_cs(mem_cs), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .halted(halted), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  assign mem_rdata = mem[mem_addr];

  // Data memory commits on the falling edge.
  always @(negedge clk) begin
    if (mem_cs && mem_write)
      mem[mem_addr] = mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 512; i++) begin
      rom[i] = '0;
      mem[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_mems();

    // Reset state
    tick(2);
    checkOutput("rst_busy",   32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_pc",     32'(pc), 32'd0);
    checkOutput("rst_count",  32'(instr_count), 32'd0);
    checkOutput("rst_strobes", 32'({rom_cs, rom_read, mem_cs, mem_read, mem_write}), 32'd0);
    checkOutput("rst_addrs",  32'({rom_addr, mem_addr, mem_wdata}), 32'd0);

    // Program: taken branch to 6, then zero result self-loop at 6
    rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h006;
    rom[6] = 9'h012; rom[7] = 9'h012; rom[8] = 9'h006;
    mem[9'h010] = 16'd5; mem[9'h011] = 16'd3; mem[9'h012] = 16'd7;
    reset = 1'b0;
    applyStimulus();
    checkOutput("fa_rom_cs",   32'({rom_cs, rom_read}), 32'b11);
    checkOutput("fa_rom_addr", 32'(rom_addr), 32'h000);
    checkOutput("fa_busy",     32'(busy), 32'd1);
    tick(1);
    checkOutput("fb_rom_addr", 32'(rom_addr), 32'h001);
    tick(1);
    checkOutput("fc_rom_addr", 32'(rom_addr), 32'h002);
    tick(1);
    checkOutput("ra_mem", 32'({mem_cs, mem_read, mem_write, mem_addr}), {29'd0, 3'b110} << 9 | 32'h010);
    tick(1);
    checkOutput("rb_mem_addr", 32'(mem_addr), 32'h011);
    tick(1);
    checkOutput("wr_strobes", 32'({mem_cs, mem_read, mem_write}), 32'b101);
    checkOutput("wr_wdata",   32'(mem_wdata), 32'hFFFE);
    tick(1);
    checkOutput("p1_mem011", 32'(mem[9'h011]), 32'hFFFE);
    checkOutput("p1_pc",     32'(pc), 32'h006);
    checkOutput("p1_count",  32'(instr_count), 32'd1);
    checkOutput("p1_rom_addr", 32'(rom_addr), 32'h006);
    tick(5);
    checkOutput("p1_halt_early", 32'(halted), 32'd0);
    tick(1);
    checkOutput("p1_halted", 32'(halted), 32'd1);
    checkOutput("p1_busy_h", 32'(busy), 32'd0);
    checkOutput("p1_mem012", 32'(mem[9'h012]), 32'h0000);
    checkOutput("p1_count2", 32'(instr_count), 32'd2);
    tick(3);
    checkOutput("halt_hold_pc", 32'({pc, instr_count}), {16'h0006, 16'd2} & 32'h01FF_FFFF);

    // Start in HALT restarts from pc 0
    applyStimulus();
    checkOutput("restart_pc",    32'(pc), 32'd0);
    checkOutput("restart_count", 32'(instr_count), 32'd0);
    checkOutput("restart_addr",  32'(rom_addr), 32'h000);
    checkOutput("restart_busy",  32'({busy, halted}), 32'b10);

    // Not-taken and overflow, with a start pulse in RB
    do_reset();
    clear_mems();
    rom[0] = 9'h020; rom[1] = 9'h021; rom[2] = 9'h100;
    rom[3] = 9'h022; rom[4] = 9'h023; rom[5] = 9'h100;
    mem[9'h020] = 16'd3;      mem[9'h021] = 16'd5;
    mem[9'h022] = 16'h0001;   mem[9'h023] = 16'h8000;
    applyStimulus();
    tick(4);
    checkOutput("rb_state_addr", 32'(mem_addr), 32'h021);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("busy_start_wr", 32'({mem_write, mem_addr}), 32'h200 | 32'h021);
    tick(1);
    checkOutput("nt_mem021", 32'(mem[9'h021]), 32'h0002);
    checkOutput("nt_pc",     32'(pc), 32'h003);
    checkOutput("nt_count",  32'(instr_count), 32'd1);
    tick(6);
    checkOutput("ovf_mem023", 32'(mem[9'h023]), 32'h7FFF);
    checkOutput("ovf_pc",     32'(pc), 32'h006);
    checkOutput("ovf_count",  32'(instr_count), 32'd2);

    // Address wrap: branch to 1FE, not-taken there -> pc 001
    do_reset();
    clear_mems();
    rom[0] = 9'h030; rom[1] = 9'h030; rom[2] = 9'h1FE;
    rom[9'h1FE] = 9'h031; rom[9'h1FF] = 9'h032;
    mem[9'h031] = 16'd1; mem[9'h032] = 16'd4;
    applyStimulus();
    tick(6);
    checkOutput("wrap_pc",  32'(pc), 32'h1FE);
    checkOutput("wrap_fa",  32'(rom_addr), 32'h1FE);
    tick(1);
    checkOutput("wrap_fb",  32'(rom_addr), 32'h1FF);
    tick(1);
    checkOutput("wrap_fc",  32'(rom_addr), 32'h000);
    tick(4);
    checkOutput("wrap_next_pc", 32'(pc), 32'h001);
    checkOutput("wrap_mem032",  32'(mem[9'h032]), 32'h0003);

    // Reset during WR blocks the write
    do_reset();
    clear_mems();
    rom[0] = 9'h040; rom[1] = 9'h041; rom[2] = 9'h000;
    mem[9'h040] = 16'd2; mem[9'h041] = 16'd9;
    applyStimulus();
    tick(5);
    checkOutput("wr_pre_reset", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("wr_gated", 32'(mem_write), 32'd0);
    tick(1);
    checkOutput("wr_rst_mem", 32'(mem[9'h041]), 32'd9);
    checkOutput("wr_rst_count", 32'(instr_count), 32'd0);
    checkOutput("wr_rst_idle", 32'({busy, halted, rom_cs, mem_cs}), 32'd0);
    reset = 1'b0;
    tick(2);
    checkOutput("idle_stays", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/urisc_core.md
URISC_CORE -- requirements
Module: urisc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width.
REQ-002 SHALL have parameter DEPTH, default 512: depth of both memories; AW = clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that launches program execution.
REQ-006 SHALL have ports rom_cs, rom_read, output, 1 each: instruction ROM select and read strobe.
REQ-007 SHALL have ports rom_addr (output, AW) and rom_data (input, AW): ROM word address and combinational read data.
REQ-008 SHALL have ports mem_cs, mem_read, mem_write, output, 1 each: data memory select, read and write strobes.
REQ-009 SHALL have port mem_addr, output, AW: data memory address.
REQ-010 SHALL have ports mem_wdata (output, WIDTH) and mem_rdata (input, WIDTH): write data and combinational read data.
REQ-011 SHALL have port busy, output, 1: high while executing.
REQ-012 SHALL have port halted, output, 1: high in the HALT state.
REQ-013 SHALL have port pc, output, AW: address of the current instruction.
REQ-014 SHALL have port instr_count, output, 16: number of retired instructions, wrapping.

Function
REQ-015 SHALL execute one instruction, "A B C", held in three consecutive ROM words at pc, pc+1 and pc+2 (mod DEPTH): Mem[B] <= Mem[B] - Mem[A]; if the result is <= 0 then pc <= C, else pc <= pc+3 (mod DEPTH).
REQ-016 SHALL implement states IDLE, FA, FB, FC, RA, RB, WR and HALT, each lasting one cycle except IDLE and HALT.
REQ-017 SHALL on start in IDLE or HALT clear pc and instr_count and go to FA; start SHALL be ignored in all other states.
REQ-018 SHALL in FA, FB and FC drive rom_cs = rom_read = 1 with rom_addr = pc, pc+1 and pc+2 respectively, latching rom_data into regA, regB and regC at the rising edge.
REQ-019 SHALL in RA drive mem_cs = mem_read = 1 and mem_addr = regA, latching opA; in RB do the same with mem_addr = regB, latching opB.
REQ-020 SHALL in WR drive mem_cs = mem_write = 1, mem_addr = regB and mem_wdata = opB - opA, truncated to WIDTH bits; the memory commits on the falling clock edge.
REQ-021 SHALL use "<= 0" to mean result[WIDTH-1] = 1 or result = 0, tested on the truncated result; overflow SHALL wrap silently.
REQ-022 SHALL at the WR rising edge update pc, increment instr_count, and go to HALT if the branch is taken and C = pc (self-loop); otherwise it SHALL go to FA.
REQ-023 SHALL take exactly 6 cycles per instruction, with no pipelining.
REQ-024 SHALL hold all strobes at 0 and rom_addr, mem_addr and mem_wdata at 0 outside their active states.
REQ-025 SHALL hold busy = 1 in FA..WR and halted = 1 in HALT; pc and instr_count SHALL hold their values in HALT.
REQ-026 SHALL derive the strobes combinationally from state; mem_write SHALL additionally be gated by !reset, so that no write occurs in a cycle in which reset is high.

Reset
REQ-027 SHALL on a rising edge with reset = 1 enter IDLE and clear pc, instr_count, regA, regB, regC, opA and opB; busy and halted SHALL be 0.
REQ-028 SHALL give reset priority over start and over every state transition, including mid-instruction.

Verification
REQ-029 SHALL verify reset: reset high for 2 cycles -> all outputs 0, IDLE; start pulse -> FA with rom_addr = 0 on the next cycle.
REQ-030 SHALL verify a program: ROM[0..2] = 010,011,006, ROM[6..8] = 012,012,006, Mem[010] = 5, Mem[011] = 3 -> Mem[011] = FFFE at the first WR, pc = 6, then Mem[012] = 0 and a self-loop -> halted = 1 twelve cycles after start, instr_count = 2.
REQ-031 SHALL verify not-taken and overflow: Mem[A] = 3, Mem[B] = 5 -> 0002, pc = 3; Mem[A] = 0001, Mem[B] = 8000 -> 7FFF, not taken.
REQ-032 SHALL verify address wrap: a branch to pc = 1FE with a not-taken result -> fetches at 1FE, 1FF and 000, next pc = 001.
REQ-033 SHALL verify reset during WR: reset asserted in the WR cycle -> target word unchanged, state IDLE, instr_count = 0.
REQ-034 SHALL verify start while busy: a start pulse in RB -> ignored, sequence and instr_count unaffected; start in HALT -> restart from pc = 0.
